interleaver_multimode: RTL and testbench
========================================

// Module: interleaver_multimode
// PURPOSE
//  Runtime-selectable 802.16 block interleaver (BPSK/QPSK/16QAM/64QAM); successor of the fixed-QPSK interleaver.
//  Sits between FEC encoder and mapper; bit-serial in/out with ready/valid on both sides.
//  Ping-pong banks: one block is written (permuted) while the previous block is read sequentially.
// PARAMETERS
//  N_CARRIERS  96   data carriers per block; Ncbps = N_CARRIERS*Ncpc
//  D           16   interleaver column count d; N_CARRIERS*Ncpc must be divisible by D for every mode
//  NCBPS_MAX   576  bank depth in bits (= N_CARRIERS*6)
//  AW          10   address width, $clog2(NCBPS_MAX)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  mode       in   2   0 BPSK(Ncpc1) 1 QPSK(2) 2 16QAM(4) 3 64QAM(6); sampled at block start
//  data_in    in   1   coded bit from FEC
//  valid_in   in   1   data_in valid
//  ready_out  out  1   block can accept data_in this cycle
//  data_out   out  1   interleaved bit to mapper
//  valid_out  out  1   data_out valid
//  ready_in   in   1   downstream accepts data_out
//  last_out   out  1   data_out is final bit of its block
//  mode_out   out  2   mode of the block currently being read
// BEHAVIOUR
//  Reset: ready_out=1, valid_out=0, data_out=0, last_out=0, mode_out=0; both banks empty, all counters 0.
//  Reset mid-block discards all stored/partial data; no partial block is ever emitted.
//  Input transfer: valid_in && ready_out. Output transfer: valid_out && ready_in.
//  Block start = first input transfer with write count k=0: latch mode into bank's mode tag.
//  Mode changes during a block have no effect until the next block start.
//  Ncbps = N_CARRIERS*Ncpc (96/192/384/576); s = max(Ncpc/2,1) (1/1/2/3).
//  Write address for input bit k: m = (Ncbps/D)*(k mod D) + floor(k/D);
//   j = s*floor(m/s) + (m + Ncbps - (k mod D)) mod s; bank[j] <= data_in. No dividers:
//   keep col=k mod D, row=floor(k/D), m incrementally (m += Ncbps/D; on col wrap m = row+1);
//   mod-3 via small combinational function on AW bits; mod 2 = LSB; mod 1 = 0.
//  On input transfer with k = Ncbps-1: write bank marked full, k/col/row/m reset to 0.
//  Bank FSM per bank: EMPTY -> FILLING (write ptr on it) -> FULL -> READING -> EMPTY.
//  Write ptr toggles to other bank at block end; if that bank is not EMPTY, ready_out=0 until it empties.
//  Read side: when read bank FULL, load bank[0] into data_out register; valid_out rises
//   the cycle after the last input bit of the block was accepted (1-cycle latency).
//  Reads sequential 0..Ncbps-1 of bank's own mode tag; data_out/last_out/mode_out held stable while ready_in=0.
//  last_out=1 with bit Ncbps-1; on its transfer bank -> EMPTY; if other bank FULL, its bit 0
//   is presented next cycle with no bubble; else valid_out=0.
//  Simultaneous final write into bank A and final read from bank B in same cycle: both complete;
//   ready_out stays 1, next writes go to B.
//  Sustained throughput 1 bit/cycle each side when ready_in=1 continuously.
// STRUCTURE
//  Package interleaver_pkg: mode_t enum {MOD_BPSK,MOD_QPSK,MOD_16QAM,MOD_64QAM}, functions
//   ncpc(mode), ncbps(mode), s_of(mode), mod3(); bank_state_t enum {EMPTY,FILLING,FULL,READING}.
//  Sub-module interleaver_addr_gen: incremental k->j generator (counters + j combinational),
//   inputs mode/advance/clear, output j and last flag. Top holds banks, bank FSMs, read logic.
//  Banks: 2 x NCBPS_MAX single-bit arrays, 1 write + 1 read port each (RAM-inferable).
// TESTING
//  1 QPSK golden: feed 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA MSB-first, ready_in=1
//    -> output 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E, last_out on bit 191; repeat 5 blocks back-to-back, no bubbles.
//  2 BPSK: input bit k = (k==5) only -> single 1 at output index m=(96/16)*5+0=30; Ncbps=96, last_out at 95.
//  3 Mode switch: QPSK block, then 64QAM block (mode changed mid first block) -> 192 then 576 outputs,
//    mode_out 1 then 3; 64QAM output matches reference model (s=3 path).
//  4 Backpressure: ready_in random 50% -> ready_out falls after 2 full blocks held, data_out stable
//    while stalled, output stream identical to scenario 1.
//  5 Reset mid-block: reset after 100 bits of second block -> next cycle valid_out=0, ready_out=1;
//    fresh golden block after reset reproduces scenario 1 output exactly.

Source files
------------

// File: rtl/interleaver_multimode_pkg.sv
// Shared types, sizes and per-mode helper functions for the multimode 802.16 block interleaver.
package interleaver_pkg;

  localparam int unsigned N_CARRIERS = 96;
  localparam int unsigned D          = 16;
  localparam int unsigned NCBPS_MAX  = 576;
  localparam int unsigned AW         = 10;
  localparam int unsigned CW         = $clog2(D);

  typedef enum logic [1:0] {MOD_BPSK, MOD_QPSK, MOD_16QAM, MOD_64QAM} mode_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

  function automatic logic [2:0] ncpc(input mode_t m);
    logic [2:0] r;
    case (m)
      MOD_BPSK:  r = 3'd1;
      MOD_QPSK:  r = 3'd2;
      MOD_16QAM: r = 3'd4;
      default:   r = 3'd6;
    endcase
    return r;
  endfunction

  function automatic logic [AW-1:0] ncbps(input mode_t m);
    return AW'(N_CARRIERS * ncpc(m));
  endfunction

  function automatic logic [1:0] s_of(input mode_t m);
    logic [1:0] r;
    case (m)
      MOD_16QAM: r = 2'd2;
      MOD_64QAM: r = 2'd3;
      default:   r = 2'd1;
    endcase
    return r;
  endfunction

  // Bit-serial remainder: r = (2r + bit) mod 3, MSB first; no divider needed.
  function automatic logic [1:0] mod3(input logic [AW-1:0] v);
    logic [2:0] t;
    logic [1:0] r;
    r = 2'd0;
    for (int i = AW - 1; i >= 0; i--) begin
      t = {r, v[i]};
      if (t >= 3'd3) t = t - 3'd3;
      r = t[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/interleaver_multimode_if.sv
// Bit-serial stream bundle: upstream ready/valid input, downstream ready/valid output with framing.
interface interleaver_multimode_if;
  logic [1:0] mode;
  logic       data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       valid_out;
  logic       ready_in;
  logic       last_out;
  logic [1:0] mode_out;

  modport slave (
    input  mode, data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_out, mode_out
  );

  modport master (
    output mode, data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_out, mode_out
  );
endinterface

// File: rtl/interleaver_multimode_addr_gen.sv
// Incremental k -> j write-address generator; keeps col/row/m counters so no division is needed.
module interleaver_addr_gen
  import interleaver_pkg::*;
(
  input  logic          clk,
  input  logic          i_clear,
  input  mode_t         i_mode,
  input  logic          i_advance,
  output logic [AW-1:0] o_j,
  output logic          o_first,
  output logic          o_last
);

  logic [AW-1:0] r_k;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_m;
  logic [CW-1:0] r_col;
  logic [AW-1:0] w_step;
  logic [1:0]    w_m3;
  logic [1:0]    w_c3;
  logic [1:0]    w_diff;

  assign w_step  = ncbps(i_mode) >> CW;
  assign o_first = (r_k == '0);
  assign o_last  = (r_k == ncbps(i_mode) - AW'(1));
  assign w_m3    = mod3(r_m);
  assign w_c3    = mod3(AW'(r_col));

  // Ncbps is a multiple of s in every mode, so it drops out of (m + Ncbps - col) mod s.
  always_comb begin
    w_diff = w_m3 + 2'd3 - w_c3;
    if (w_m3 >= w_c3) w_diff = w_m3 - w_c3;
    case (s_of(i_mode))
      2'd2:    o_j = {r_m[AW-1:1], r_m[0] ^ r_col[0]};
      2'd3:    o_j = r_m - AW'(w_m3) + AW'(w_diff);
      default: o_j = r_m;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_clear || (i_advance && o_last)) begin
      r_k   <= '0;
      r_row <= '0;
      r_m   <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      r_k <= r_k + AW'(1);
      if (r_col == CW'(D - 1)) begin
        r_col <= '0;
        r_row <= r_row + AW'(1);
        r_m   <= r_row + AW'(1);
      end else begin
        r_col <= r_col + CW'(1);
        r_m   <= r_m + w_step;
      end
    end
  end

endmodule

// File: rtl/interleaver_multimode.sv
// Ping-pong multimode block interleaver: permuted writes into one bank, sequential reads of the other.
module interleaver_multimode
  import interleaver_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  interleaver_multimode_if.slave bus
);

  logic          r_bank0 [NCBPS_MAX];
  logic          r_bank1 [NCBPS_MAX];
  bank_state_t   r_state [2];
  bank_state_t   w_state_d [2];
  mode_t         r_mode_tag [2];
  logic          r_wr_sel;
  logic          r_rd_sel;
  logic [AW-1:0] r_rd_addr;
  logic          r_data_out;
  logic          r_valid_out;
  logic          r_last_out;
  mode_t         r_mode_out;

  logic          w_wr_fire;
  logic          w_first;
  logic          w_last;
  logic [AW-1:0] w_j;
  mode_t         w_wr_mode;
  logic          w_rd_fire;
  logic          w_cur_done;
  logic          w_load_seq;
  logic          w_load_new;
  logic          w_next_sel;
  logic          w_next_avail;
  logic          w_rd_bank;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_bit;

  assign bus.ready_out = (r_state[r_wr_sel] == EMPTY) || (r_state[r_wr_sel] == FILLING);
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.last_out  = r_last_out;
  assign bus.mode_out  = r_mode_out;

  assign w_wr_fire = bus.valid_in && bus.ready_out;
  assign w_wr_mode = w_first ? mode_t'(bus.mode) : r_mode_tag[r_wr_sel];

  interleaver_addr_gen u_addr_gen (
    .clk       (clk),
    .i_clear   (reset),
    .i_mode    (w_wr_mode),
    .i_advance (w_wr_fire),
    .o_j       (w_j),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  // A bank completing this very cycle counts as available, giving the 1-cycle fill-to-valid latency.
  assign w_rd_fire    = r_valid_out && bus.ready_in;
  assign w_cur_done   = w_rd_fire && r_last_out;
  assign w_load_seq   = w_rd_fire && !r_last_out;
  assign w_next_sel   = w_cur_done ? ~r_rd_sel : r_rd_sel;
  assign w_next_avail = (r_state[w_next_sel] == FULL) ||
                        (w_wr_fire && w_last && (r_wr_sel == w_next_sel));
  assign w_load_new   = (!r_valid_out || w_cur_done) && w_next_avail;
  assign w_rd_bank    = w_load_new ? w_next_sel : r_rd_sel;
  assign w_rd_addr    = w_load_new ? '0 : r_rd_addr;
  assign w_rd_bit     = w_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_d[b] = r_state[b];
      if (w_wr_fire && (r_wr_sel == 1'(b))) w_state_d[b] = w_last ? FULL : FILLING;
      if (w_cur_done && (r_rd_sel == 1'(b))) w_state_d[b] = EMPTY;
      if (w_load_new && (w_next_sel == 1'(b))) w_state_d[b] = READING;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire && !reset) begin
      if (r_wr_sel) r_bank1[w_j] <= bus.data_in;
      else          r_bank0[w_j] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state[0]    <= EMPTY;
      r_state[1]    <= EMPTY;
      r_mode_tag[0] <= MOD_BPSK;
      r_mode_tag[1] <= MOD_BPSK;
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_rd_addr     <= '0;
      r_data_out    <= 1'b0;
      r_valid_out   <= 1'b0;
      r_last_out    <= 1'b0;
      r_mode_out    <= MOD_BPSK;
    end else begin
      r_state[0] <= w_state_d[0];
      r_state[1] <= w_state_d[1];
      if (w_wr_fire && w_first) r_mode_tag[r_wr_sel] <= mode_t'(bus.mode);
      if (w_wr_fire && w_last) r_wr_sel <= ~r_wr_sel;
      if (w_cur_done) r_rd_sel <= ~r_rd_sel;
      if (w_load_new) begin
        r_data_out  <= w_rd_bit;
        r_valid_out <= 1'b1;
        r_last_out  <= 1'b0;
        r_mode_out  <= r_mode_tag[w_next_sel];
        r_rd_addr   <= AW'(1);
      end else if (w_load_seq) begin
        r_data_out <= w_rd_bit;
        r_last_out <= (r_rd_addr == ncbps(r_mode_out) - AW'(1));
        r_rd_addr  <= r_rd_addr + AW'(1);
      end else if (w_cur_done) begin
        r_valid_out <= 1'b0;
        r_last_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_multimode.sv
// Randomised self-checking bench: behavioural permutation model, golden vectors, stall and reset checks.
module tb_interleaver_multimode;

  localparam logic [191:0] GOLD_IN  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
  localparam logic [191:0] GOLD_OUT = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interleaver_multimode_if bus ();

  interleaver_multimode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int bubbles = 0;
  bit golden_on = 1'b0;
  bit rand_rdy = 1'b0;
  bit abort = 1'b0;

  bit         in_q[$];
  logic [1:0] in_mode;
  bit         exp_d[$];
  bit         exp_l[$];
  logic [1:0] exp_m[$];
  int         out_cnt = 0;
  int         cur_one = -1;
  logic [191:0] cap = '0;
  int         len_hist[$];
  int         one_hist[$];
  logic [1:0] mode_hist[$];
  bit         stall_prev = 1'b0;
  logic       prev_d, prev_l;
  logic [1:0] prev_m;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ncpc_of(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 6;
  endfunction

  // Output position of input bit k, straight from the two-step 802.16 permutation.
  function automatic int perm_pos(input int k, input int ncpc);
    int n, s, c, m;
    n = 96 * ncpc;
    s = (ncpc / 2 > 1) ? ncpc / 2 : 1;
    c = k % 16;
    m = (n / 16) * c + k / 16;
    return s * (m / s) + (m + n - c) % s;
  endfunction

  task automatic model_complete();
    int n;
    bit ob[];
    n = in_q.size();
    ob = new[n];
    for (int k = 0; k < n; k++) ob[perm_pos(k, ncpc_of(in_mode))] = in_q[k];
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(ob[i]);
      exp_l.push_back(i == n - 1);
      exp_m.push_back(in_mode);
    end
    in_q.delete();
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      in_q.delete();
      exp_d.delete();
      exp_l.delete();
      exp_m.delete();
      out_cnt = 0;
      cur_one = -1;
      cap = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", bus.valid_out, 1'b1);
        check_eq("stall_data", bus.data_out, prev_d);
        check_eq("stall_last", bus.last_out, prev_l);
        check_eq("stall_mode", bus.mode_out, prev_m);
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_d.size() == 0) begin
          check_eq("out_unexpected", bus.valid_out, 1'b0);
        end else begin
          check_eq("out_data", bus.data_out, exp_d.pop_front());
          check_eq("out_last", bus.last_out, exp_l.pop_front());
          check_eq("out_mode", bus.mode_out, exp_m.pop_front());
          cap = {cap[190:0], bus.data_out};
          if (bus.data_out) cur_one = out_cnt;
          out_cnt++;
          if (bus.last_out) begin
            if (golden_on && out_cnt == 192) check_eq("golden_block", cap, GOLD_OUT);
            len_hist.push_back(out_cnt);
            one_hist.push_back(cur_one);
            mode_hist.push_back(bus.mode_out);
            out_cnt = 0;
            cur_one = -1;
          end
        end
      end else if (bus.ready_in && !bus.valid_out && exp_d.size() > 0) begin
        bubbles++;
      end
      stall_prev = bus.valid_out && !bus.ready_in;
      prev_d = bus.data_out;
      prev_l = bus.last_out;
      prev_m = bus.mode_out;
      if (bus.valid_in && bus.ready_out) begin
        if (in_q.size() == 0) in_mode = bus.mode;
        in_q.push_back(bus.data_in);
        if (in_q.size() == 96 * ncpc_of(in_mode)) model_complete();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.ready_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_bit(input logic [1:0] md, input bit b);
    int waitc;
    waitc = 0;
    if (abort) return;
    bus.mode = md;
    bus.data_in = b;
    bus.valid_in = 1'b1;
    @(negedge clk);
    while (!bus.ready_out && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.ready_out) begin
      check_eq("ready_out_timeout", bus.ready_out, 1'b1);
      abort = 1'b1;
      bus.valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  // kind: 0 random bits, 1 golden vector MSB-first, 2 single one at k=5.
  task automatic send_block(input int kind, input logic [1:0] md0, input logic [1:0] md1,
                            input int sw, input int n, input bit gaps);
    logic [191:0] pat;
    pat = GOLD_IN;
    for (int k = 0; k < n; k++) begin
      bit b;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      case (kind)
        0:       b = 1'($urandom_range(0, 1));
        1:       b = pat[191-k];
        default: b = (k == 5);
      endcase
      send_bit((k < sw) ? md0 : md1, b);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_d.size() > 0 || bus.valid_out) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check_eq("drain_pending", exp_d.size(), 0);
    check_eq("drain_partial_in", in_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    len_hist.delete();
    one_hist.delete();
    mode_hist.delete();
  endtask

  initial begin
    int t0;
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    bus.mode     = 2'd0;
    bus.ready_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready_out", bus.ready_out, 1'b1);
    check_eq("rst_valid_out", bus.valid_out, 1'b0);
    check_eq("rst_data_out", bus.data_out, 1'b0);
    check_eq("rst_last_out", bus.last_out, 1'b0);
    check_eq("rst_mode_out", bus.mode_out, 2'd0);
    reset = 1'b0;

    // QPSK golden, five blocks back-to-back
    golden_on = 1'b1;
    bubbles = 0;
    clear_hist();
    t0 = cyc;
    for (int b = 0; b < 5; b++) send_block(1, 2'd1, 2'd1, 192, 192, 1'b0);
    check_eq("s1_in_cycles", cyc - t0, 960);
    wait_idle();
    check_eq("s1_blocks", len_hist.size(), 5);
    check_eq("s1_bubbles", bubbles, 0);
    foreach (len_hist[i]) check_eq("s1_block_len", len_hist[i], 192);
    golden_on = 1'b0;

    // BPSK single one
    clear_hist();
    send_block(2, 2'd0, 2'd0, 96, 96, 1'b0);
    wait_idle();
    check_eq("s2_blocks", len_hist.size(), 1);
    if (len_hist.size() == 1) begin
      check_eq("s2_len", len_hist[0], 96);
      check_eq("s2_one_pos", one_hist[0], 30);
      check_eq("s2_mode", mode_hist[0], 2'd0);
    end

    // QPSK with mid-block mode change, then 64QAM, random data and input gaps
    clear_hist();
    send_block(0, 2'd1, 2'd3, 100, 192, 1'b1);
    send_block(0, 2'd3, 2'd3, 576, 576, 1'b1);
    wait_idle();
    check_eq("s3_blocks", len_hist.size(), 2);
    if (len_hist.size() == 2) begin
      check_eq("s3_len0", len_hist[0], 192);
      check_eq("s3_mode0", mode_hist[0], 2'd1);
      check_eq("s3_len1", len_hist[1], 576);
      check_eq("s3_mode1", mode_hist[1], 2'd3);
    end

    // Backpressure: two blocks held, then random downstream ready
    golden_on = 1'b1;
    clear_hist();
    bus.ready_in = 1'b0;
    for (int b = 0; b < 2; b++) send_block(1, 2'd1, 2'd1, 192, 192, 1'b0);
    check_eq("s4_ready_low", bus.ready_out, 1'b0);
    check_eq("s4_valid_held", bus.valid_out, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("s4_ready_still_low", bus.ready_out, 1'b0);
    rand_rdy = 1'b1;
    for (int b = 0; b < 2; b++) send_block(1, 2'd1, 2'd1, 192, 192, 1'b0);
    rand_rdy = 1'b0;
    bus.ready_in = 1'b1;
    wait_idle();
    check_eq("s4_blocks", len_hist.size(), 4);
    golden_on = 1'b0;

    // Reset 100 bits into the second block, then a fresh golden block
    golden_on = 1'b1;
    send_block(1, 2'd1, 2'd1, 192, 192, 1'b0);
    send_block(1, 2'd1, 2'd1, 192, 100, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("s5_valid_after_rst", bus.valid_out, 1'b0);
    check_eq("s5_ready_after_rst", bus.ready_out, 1'b1);
    check_eq("s5_last_after_rst", bus.last_out, 1'b0);
    clear_hist();
    send_block(1, 2'd1, 2'd1, 192, 192, 1'b0);
    wait_idle();
    check_eq("s5_blocks", len_hist.size(), 1);
    if (len_hist.size() == 1) check_eq("s5_len", len_hist[0], 192);
    golden_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
